// File: rtl/fifo_memory.sv
// Single-clock 16x8 FIFO with registered read data and count-decoded full/empty flags.
// Full frees a slot for a write when a read is accepted on the same edge.
module fifo_memory #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write_Enable,
    input  logic                  read_Enable,
    input  logic [DATA_WIDTH-1:0] buffer_Input,
    output logic [DATA_WIDTH-1:0] buffer_Output,
    output logic                  sig_Full,
    output logic                  sig_Empty
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  wr_acc;
    logic                  rd_acc;

    assign sig_Full  = (count == FULL_CNT);
    assign sig_Empty = (count == '0);
    assign rd_acc    = read_Enable && !sig_Empty;
    assign wr_acc    = write_Enable && (!sig_Full || rd_acc);

    // Storage is deliberately left out of reset; pointers and count define validity.
    always_ff @(posedge clock) begin
        if (wr_acc && !reset)
            mem[wr_ptr] <= buffer_Input;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            buffer_Output <= '0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) begin
                buffer_Output <= mem[rd_ptr];
                rd_ptr        <= rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_memory.sv
// Directed self-checking bench for fifo_memory: reset, fill/drain, overflow/underflow,
// simultaneous access, pointer wrap and reset during operation.
module tb_fifo_memory;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       write_Enable = 1'b0;
    logic       read_Enable = 1'b0;
    logic [7:0] buffer_Input = 8'h00;
    logic [7:0] buffer_Output;
    logic       sig_Full;
    logic       sig_Empty;

    int errors = 0;
    int checks = 0;

    fifo_memory #(.DATA_WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .write_Enable  (write_Enable),
        .read_Enable   (read_Enable),
        .buffer_Input  (buffer_Input),
        .buffer_Output (buffer_Output),
        .sig_Full      (sig_Full),
        .sig_Empty     (sig_Empty)
    );

    always #5 clock = ~clock;

    // One clock edge with the given enables; returns 1 time unit after the edge, enables idle.
    task automatic cyc(input logic we, input logic re, input logic [7:0] din);
        write_Enable = we;
        read_Enable  = re;
        buffer_Input = din;
        @(posedge clock);
        #1;
        write_Enable = 1'b0;
        read_Enable  = 1'b0;
    endtask

    task automatic test_reset;
        #2 reset = 1'b1;
        #1;
        checks++; if (buffer_Output !== 8'h00) begin errors++; $display("FAIL reset_out got=%h exp=00", buffer_Output); end
        checks++; if (sig_Empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", sig_Empty); end
        checks++; if (sig_Full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", sig_Full); end
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'hFF);
        checks++; if (buffer_Output !== 8'h00 || sig_Empty !== 1'b1 || sig_Full !== 1'b0) begin
            errors++; $display("FAIL reset_idle got=%h/%b/%b exp=00/1/0", buffer_Output, sig_Empty, sig_Full);
        end
    endtask

    task automatic test_fill_drain;
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 1'b0, 8'(i));
            checks++; if (sig_Empty !== 1'b0) begin errors++; $display("FAIL fill_empty[%0d] got=%b exp=0", i, sig_Empty); end
            checks++; if (sig_Full !== (i == 16)) begin errors++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, sig_Full, (i == 16)); end
        end
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            checks++; if (buffer_Output !== 8'(i)) begin errors++; $display("FAIL drain_out[%0d] got=%h exp=%h", i, buffer_Output, 8'(i)); end
            checks++; if (sig_Empty !== (i == 16)) begin errors++; $display("FAIL drain_empty[%0d] got=%b exp=%b", i, sig_Empty, (i == 16)); end
        end
    endtask

    task automatic test_overflow_underflow;
        for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, 8'(i));
        cyc(1'b1, 1'b0, 8'hAA);
        checks++; if (sig_Full !== 1'b1) begin errors++; $display("FAIL ovf_full got=%b exp=1", sig_Full); end
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            checks++; if (buffer_Output !== 8'(i)) begin errors++; $display("FAIL ovf_out[%0d] got=%h exp=%h", i, buffer_Output, 8'(i)); end
        end
        checks++; if (sig_Empty !== 1'b1) begin errors++; $display("FAIL ovf_drained got=%b exp=1", sig_Empty); end
        cyc(1'b0, 1'b1, 8'h00);
        checks++; if (buffer_Output !== 8'h10) begin errors++; $display("FAIL udf_out got=%h exp=10", buffer_Output); end
        checks++; if (sig_Empty !== 1'b1 || sig_Full !== 1'b0) begin
            errors++; $display("FAIL udf_flags got=%b/%b exp=1/0", sig_Empty, sig_Full);
        end
    endtask

    task automatic test_simultaneous;
        cyc(1'b1, 1'b1, 8'h05);
        checks++; if (buffer_Output !== 8'h10) begin errors++; $display("FAIL sim_empty_out got=%h exp=10", buffer_Output); end
        checks++; if (sig_Empty !== 1'b0 || sig_Full !== 1'b0) begin
            errors++; $display("FAIL sim_empty_flags got=%b/%b exp=0/0", sig_Empty, sig_Full);
        end
        cyc(1'b0, 1'b1, 8'h00);
        checks++; if (buffer_Output !== 8'h05) begin errors++; $display("FAIL sim_empty_read got=%h exp=05", buffer_Output); end
        checks++; if (sig_Empty !== 1'b1) begin errors++; $display("FAIL sim_empty_after got=%b exp=1", sig_Empty); end
        for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, 8'(8'h40 + i));
        cyc(1'b1, 1'b1, 8'h77);
        checks++; if (buffer_Output !== 8'h41) begin errors++; $display("FAIL sim_full_out got=%h exp=41", buffer_Output); end
        checks++; if (sig_Full !== 1'b1) begin errors++; $display("FAIL sim_full_flag got=%b exp=1", sig_Full); end
        for (int i = 2; i <= 17; i++) begin
            logic [7:0] exp_v;
            exp_v = (i == 17) ? 8'h77 : 8'(8'h40 + i);
            cyc(1'b0, 1'b1, 8'h00);
            checks++; if (buffer_Output !== exp_v) begin errors++; $display("FAIL sim_full_drain[%0d] got=%h exp=%h", i, buffer_Output, exp_v); end
        end
        checks++; if (sig_Empty !== 1'b1) begin errors++; $display("FAIL sim_full_empty got=%b exp=1", sig_Empty); end
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 8'(8'h60 + i));
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            checks++; if (buffer_Output !== 8'(8'h60 + i)) begin errors++; $display("FAIL wrap_pre[%0d] got=%h exp=%h", i, buffer_Output, 8'(8'h60 + i)); end
        end
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h20 + i));
        checks++; if (sig_Full !== 1'b1) begin errors++; $display("FAIL wrap_full got=%b exp=1", sig_Full); end
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            checks++; if (buffer_Output !== 8'(8'h20 + i)) begin errors++; $display("FAIL wrap_out[%0d] got=%h exp=%h", i, buffer_Output, 8'(8'h20 + i)); end
        end
        checks++; if (sig_Empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got=%b exp=1", sig_Empty); end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h90 + i));
        checks++; if (sig_Empty !== 1'b0) begin errors++; $display("FAIL rmid_pre got=%b exp=0", sig_Empty); end
        #2 reset = 1'b1;
        #1;
        checks++; if (sig_Empty !== 1'b1 || buffer_Output !== 8'h00) begin
            errors++; $display("FAIL rmid_reset got=%b/%h exp=1/00", sig_Empty, buffer_Output);
        end
        #1 reset = 1'b0;
        cyc(1'b1, 1'b0, 8'h33);
        cyc(1'b0, 1'b1, 8'h00);
        checks++; if (buffer_Output !== 8'h33) begin errors++; $display("FAIL rmid_read got=%h exp=33", buffer_Output); end
        checks++; if (sig_Empty !== 1'b1) begin errors++; $display("FAIL rmid_empty got=%b exp=1", sig_Empty); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow_underflow();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_memory.md
# fifo_memory

Synchronous single-clock first-in/first-out buffer with 8-bit data, 16 entries, and full and empty status flags. It sits between a byte producer and a byte consumer in the same clock domain, decoupling their rates. Writes and reads are independent enables sampled on the rising clock edge. The read data is registered.

## Interface
- DATA_WIDTH, 8, width of each stored word and of the data ports.
- DEPTH, 16, number of storage entries; must be a power of two.
- ADDR_WIDTH, 4, log2(DEPTH); pointer width.

- clock  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous, active-high; clears all state immediately, independent of clock.
- write_Enable  input  1  request to push buffer_Input on this edge.
- read_Enable  input  1  request to pop the oldest word on this edge.
- buffer_Input  input  DATA_WIDTH  word to push.
- buffer_Output  output  DATA_WIDTH  registered word popped by the most recent accepted read.
- sig_Full  output  1  high when count == DEPTH.
- sig_Empty  output  1  high when count == 0.

## Operation
- State: storage array of DEPTH words, write pointer wr_ptr, read pointer rd_ptr (ADDR_WIDTH bits each, wrapping modulo DEPTH), occupancy count (ADDR_WIDTH+1 bits, range 0..DEPTH), output register.
- Write accepted = write_Enable && (!sig_Full || read accepted). On accept: mem[wr_ptr] <= buffer_Input; wr_ptr <= wr_ptr+1.
- Read accepted = read_Enable && !sig_Empty. On accept: buffer_Output <= mem[rd_ptr]; rd_ptr <= rd_ptr+1.
- Count update: +1 on write only, -1 on read only, unchanged on both or neither.
- Write when full with no read: ignored; storage, pointers, and count unchanged. The word is dropped.
- Read when empty: ignored; buffer_Output holds its previous value. Pointers and count are unchanged.
- Simultaneous read and write when empty: the write is accepted and the read is ignored, so count becomes 1. Data cannot be read through in the same cycle.
- Simultaneous read and write when full: both are accepted and count stays at DEPTH.
- Simultaneous read and write when partially filled: both are accepted and count is unchanged.
- Pointer wrap: DEPTH-1 increments to 0. No other special handling.
- sig_Full and sig_Empty are decoded combinationally from the count register only.
- Storage contents are not reset. Only the pointers, count, and buffer_Output are reset.

## Timing
- Reset asserted, at any time including mid-operation: wr_ptr=0, rd_ptr=0, count=0, buffer_Output=0, sig_Empty=1, sig_Full=0. All entries are discarded.
- While reset is high, all enables are ignored. Normal operation resumes on the first rising edge after deassertion.
- Write latency: a word pushed at edge N is readable from edge N+1 onward. sig_Empty falls after edge N.
- Read latency: buffer_Output updates at the same edge where the read is accepted. The value is valid after that edge and held until the next accepted read or reset.
- Flags reflect the post-edge count. There is no look-ahead or almost-full/almost-empty signalling.
- Throughput: one write and one read per cycle maximum.

## Test plan
- Reset: assert reset mid-clock with no edge -> immediately buffer_Output=0x00, sig_Empty=1, sig_Full=0. Deassert, then hold enables low for 3 edges -> outputs unchanged.
- Fill and drain: write 1..16 (write_Enable=1, read_Enable=0). sig_Full=1 after the 16th edge. Then read 16 times -> buffer_Output sequence 1,2,…,16, and sig_Empty=1 after the 16th read.
- Overflow/underflow: with the FIFO full, write 0xAA -> ignored, and subsequent reads return 1..16 with no 0xAA. Read once more when empty -> buffer_Output stays 16 (0x10) and flags are unchanged.
- Simultaneous access: when empty, write 0x05 with read -> count 1, buffer_Output unchanged, next read returns 0x05. When full, write 0x77 with read -> buffer_Output=oldest word, sig_Full stays 1, and 0x77 later emerges last.
- Wrap-around: write 10 and read 10, then write 0x20..0x2F (16 words) -> sig_Full=1, and reads return 0x20..0x2F in order across the pointer wrap.
- Reset mid-operation: with 5 words stored, pulse reset -> sig_Empty=1. Then write 0x33 and read once -> buffer_Output=0x33 (no stale words).
